// File: rtl/uart_tx_serializer.sv
// 8N1/8N2 UART transmit serializer fed by the AXI register block.
// Samples a byte and divisor on accept, shifts it out LSB first, then pulses t_done_o.
module uart_tx_serializer #(
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int GUARD_CYCLES = 2
) (
    input  logic        s_axi_aclk_i,
    input  logic        s_axi_aresetn_i,
    input  logic        tx_en_i,
    input  logic [7:0]  tx_data_i,
    input  logic [15:0] baud_div_i,
    output logic        tx_o,
    output logic        t_done_o,
    output logic        busy_o
);

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
    localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);
    localparam logic [2:0]    BIT_LAST   = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        GUARD = 3'd4
    } state_t;

    state_t         state, state_n;
    logic [15:0]    baud_cnt, baud_cnt_n;
    logic [15:0]    div_eff, div_eff_n;
    logic [2:0]     bit_idx, bit_idx_n;
    logic           stop_idx, stop_idx_n;
    logic [GW-1:0]  guard_cnt, guard_cnt_n;
    logic [7:0]     shift_q, shift_n;
    logic           tx_n, t_done_n, busy_n;
    logic           bit_end;

    // div_eff is never 0 outside IDLE, so the count peaks at div_eff-1 <= 0xFFFE.
    assign bit_end = (baud_cnt == (div_eff - 16'd1));

    always_ff @(posedge s_axi_aclk_i) begin
        if (!s_axi_aresetn_i) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            div_eff   <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            guard_cnt <= '0;
            shift_q   <= '0;
            tx_o      <= 1'b1;
            t_done_o  <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_cnt_n;
            div_eff   <= div_eff_n;
            bit_idx   <= bit_idx_n;
            stop_idx  <= stop_idx_n;
            guard_cnt <= guard_cnt_n;
            shift_q   <= shift_n;
            tx_o      <= tx_n;
            t_done_o  <= t_done_n;
            busy_o    <= busy_n;
        end
    end

    always_comb begin
        state_n     = state;
        baud_cnt_n  = baud_cnt;
        div_eff_n   = div_eff;
        bit_idx_n   = bit_idx;
        stop_idx_n  = stop_idx;
        guard_cnt_n = guard_cnt;
        shift_n     = shift_q;

        case (state)
            IDLE: begin
                if (tx_en_i) begin
                    shift_n    = tx_data_i;
                    div_eff_n  = (baud_div_i == 16'd0) ? 16'd1 : baud_div_i;
                    baud_cnt_n = '0;
                    state_n    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    state_n    = DATA;
                end else begin
                    baud_cnt_n = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    shift_n    = {1'b0, shift_q[7:1]};
                    if (bit_idx == BIT_LAST) begin
                        stop_idx_n = 1'b0;
                        state_n    = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    if (stop_idx == STOP_LAST) begin
                        guard_cnt_n = '0;
                        state_n     = GUARD;
                    end else begin
                        stop_idx_n = 1'b1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 16'd1;
                end
            end
            GUARD: begin
                if (guard_cnt == GUARD_LAST) begin
                    guard_cnt_n = '0;
                    state_n     = IDLE;
                end else begin
                    guard_cnt_n = guard_cnt + GW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered
        // yet line up with the state they describe.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
        t_done_n = (state_n == GUARD) && (state != GUARD);
        busy_n   = (state_n != IDLE);
    end

endmodule
